// File: rtl/gbuf_b_sched_if.sv
// rtl/gbuf_b_sched_if.sv - host write stream, buffer port and read-tag bundle for gbuf_b_sched
interface gbuf_b_sched_if #(
    parameter int ADDR_BITS = 16,
    parameter int DATA_BITS = 32
);
    logic                 wr_valid;
    logic                 wr_ready;
    logic [DATA_BITS-1:0] wr_data;
    logic                 buf_wr_en;
    logic [ADDR_BITS-1:0] buf_index;
    logic [DATA_BITS-1:0] buf_data_in;
    logic [2:0]           buf_buf_idx;
    logic                 buf_out;
    logic [ADDR_BITS-1:0] buf_index_out;
    logic [2:0]           buf_buf_idx_out;
    logic                 rd_valid;
    logic [2:0]           rd_bank;
    logic [ADDR_BITS-1:0] rd_row;

    // host / buffer / consumer side
    modport master (
        output wr_valid, wr_data,
        input  wr_ready, buf_wr_en, buf_index, buf_data_in, buf_buf_idx,
        input  buf_out, buf_index_out, buf_buf_idx_out, rd_valid, rd_bank, rd_row
    );

    // sequencer side
    modport slave (
        input  wr_valid, wr_data,
        output wr_ready, buf_wr_en, buf_index, buf_data_in, buf_buf_idx,
        output buf_out, buf_index_out, buf_buf_idx_out, rd_valid, rd_bank, rd_row
    );
endinterface

// File: rtl/gbuf_b_sched.sv
// rtl/gbuf_b_sched.sv - banked B-operand buffer load/stream sequencer; GBUF_B_SCHED_DBLBUF_EN enables ping-pong halves
module gbuf_b_sched #(
    parameter int ADDR_BITS = 16,
    parameter int DATA_BITS = 32,
    parameter int NBANK     = 8,
    parameter int DEPTH     = 2048
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ld_start,
    input  logic [ADDR_BITS-1:0] ld_words,
    input  logic                 st_start,
    input  logic [ADDR_BITS-1:0] st_rows,
    input  logic                 st_stall,
    output logic                 ld_done,
    output logic                 st_done,
    output logic                 busy,
    gbuf_b_sched_if.slave        bus
);
    // bit 0 = load active, bit 1 = stream active; both may be set only with ping-pong halves
    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] LOAD   = 2'b01;
    localparam logic [1:0] STREAM = 2'b10;

`ifdef GBUF_B_SCHED_DBLBUF_EN
    localparam int REGION = DEPTH / 2;
`else
    localparam int REGION = DEPTH;
`endif
    localparam logic [ADDR_BITS-1:0] IDX_LAST  = ADDR_BITS'(REGION - 1);
    localparam logic [2:0]           LAST_BANK = 3'(NBANK - 1);

    logic [1:0]           state_q, state_d;
    logic [ADDR_BITS-1:0] ld_total_q, ld_total_d, ld_cnt_q, ld_cnt_d, ld_idx_q, ld_idx_d;
    logic [2:0]           ld_bank_q, ld_bank_d;
    logic [ADDR_BITS-1:0] st_rows_q, st_rows_d, st_row_q, st_row_d, st_idx_q, st_idx_d;
    logic [2:0]           st_bank_q, st_bank_d;
    logic                 ld_done_q, ld_done_d, st_done_q, st_done_d;
    logic                 rd_valid_q, rd_valid_d;
    logic [2:0]           rd_bank_q, rd_bank_d;
    logic [ADDR_BITS-1:0] rd_row_q, rd_row_d;
    logic [ADDR_BITS-1:0] ld_base, st_base;
    logic                 ld_busy, st_busy, ld_go, st_go, wr_fire, st_issue;

`ifdef GBUF_B_SCHED_DBLBUF_EN
    logic sel_q, sel_d;
    assign ld_base = sel_q ? '0 : ADDR_BITS'(DEPTH / 2);
    assign st_base = sel_q ? ADDR_BITS'(DEPTH / 2) : '0;
`else
    assign ld_base = '0;
    assign st_base = '0;
`endif

    assign ld_busy  = state_q[0];
    assign st_busy  = state_q[1];
    assign wr_fire  = bus.wr_valid & ld_busy;
    assign st_issue = st_busy & ~st_stall;

    // start arbitration: ld_start wins a tie; stream only starts with the loader idle
`ifdef GBUF_B_SCHED_DBLBUF_EN
    assign ld_go = ld_start & ~ld_busy;
    assign st_go = st_start & ~ld_start & ~ld_busy & ~st_busy;
`else
    assign ld_go = ld_start & (state_q == IDLE);
    assign st_go = st_start & ~ld_start & (state_q == IDLE);
`endif

    // next-state for the load scatter and the stream gather counters
    always_comb begin
        state_d    = state_q;
        ld_total_d = ld_total_q;
        ld_cnt_d   = ld_cnt_q;
        ld_idx_d   = ld_idx_q;
        ld_bank_d  = ld_bank_q;
        st_rows_d  = st_rows_q;
        st_row_d   = st_row_q;
        st_idx_d   = st_idx_q;
        st_bank_d  = st_bank_q;
        ld_done_d  = 1'b0;
        st_done_d  = 1'b0;
        rd_valid_d = st_issue;
        rd_bank_d  = st_bank_q;
        rd_row_d   = st_row_q;
`ifdef GBUF_B_SCHED_DBLBUF_EN
        sel_d      = sel_q;
`endif
        if (ld_go) begin
            ld_total_d = ld_words;
            ld_cnt_d   = '0;
            ld_idx_d   = '0;
            ld_bank_d  = '0;
            if (ld_words == '0) ld_done_d  = 1'b1;
            else                state_d[0] = 1'b1;
        end else if (wr_fire) begin
            if (ld_cnt_q == ld_total_q - ADDR_BITS'(1)) begin
                state_d[0] = 1'b0;
                ld_done_d  = 1'b1;
            end else begin
                ld_cnt_d = ld_cnt_q + ADDR_BITS'(1);
                if (ld_bank_q == LAST_BANK) begin
                    ld_bank_d = '0;
                    ld_idx_d  = (ld_idx_q == IDX_LAST) ? '0 : ld_idx_q + ADDR_BITS'(1);
                end else begin
                    ld_bank_d = ld_bank_q + 3'd1;
                end
            end
        end

        if (st_go) begin
            st_rows_d = st_rows;
            st_row_d  = '0;
            st_idx_d  = '0;
            st_bank_d = '0;
`ifdef GBUF_B_SCHED_DBLBUF_EN
            sel_d     = ~sel_q;
`endif
            if (st_rows == '0) st_done_d  = 1'b1;
            else               state_d[1] = 1'b1;
        end else if (st_issue) begin
            if (st_bank_q == LAST_BANK) begin
                st_bank_d = '0;
                if (st_row_q == st_rows_q - ADDR_BITS'(1)) begin
                    state_d[1] = 1'b0;
                    st_done_d  = 1'b1;
                end else begin
                    st_row_d = st_row_q + ADDR_BITS'(1);
                    st_idx_d = (st_idx_q == IDX_LAST) ? '0 : st_idx_q + ADDR_BITS'(1);
                end
            end else begin
                st_bank_d = st_bank_q + 3'd1;
            end
        end
    end

    // controller registers; reset clears everything including an in-flight rd_valid
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ld_total_q <= '0;
            ld_cnt_q   <= '0;
            ld_idx_q   <= '0;
            ld_bank_q  <= '0;
            st_rows_q  <= '0;
            st_row_q   <= '0;
            st_idx_q   <= '0;
            st_bank_q  <= '0;
            ld_done_q  <= 1'b0;
            st_done_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_bank_q  <= '0;
            rd_row_q   <= '0;
`ifdef GBUF_B_SCHED_DBLBUF_EN
            sel_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            ld_total_q <= ld_total_d;
            ld_cnt_q   <= ld_cnt_d;
            ld_idx_q   <= ld_idx_d;
            ld_bank_q  <= ld_bank_d;
            st_rows_q  <= st_rows_d;
            st_row_q   <= st_row_d;
            st_idx_q   <= st_idx_d;
            st_bank_q  <= st_bank_d;
            ld_done_q  <= ld_done_d;
            st_done_q  <= st_done_d;
            rd_valid_q <= rd_valid_d;
            rd_bank_q  <= rd_bank_d;
            rd_row_q   <= rd_row_d;
`ifdef GBUF_B_SCHED_DBLBUF_EN
            sel_q      <= sel_d;
`endif
        end
    end

    // buffer-facing addresses are forced to 0 while their side is idle
    assign bus.wr_ready        = ld_busy;
    assign bus.buf_wr_en       = wr_fire;
    assign bus.buf_data_in     = bus.wr_data;
    assign bus.buf_index       = ld_busy ? ld_base + ld_idx_q : '0;
    assign bus.buf_buf_idx     = ld_busy ? ld_bank_q : 3'd0;
    assign bus.buf_out         = st_issue;
    assign bus.buf_index_out   = st_busy ? st_base + st_idx_q : '0;
    assign bus.buf_buf_idx_out = st_busy ? st_bank_q : 3'd0;
    assign bus.rd_valid        = rd_valid_q;
    assign bus.rd_bank         = rd_bank_q;
    assign bus.rd_row          = rd_row_q;
    assign ld_done             = ld_done_q;
    assign st_done             = st_done_q;
    assign busy                = (state_q != IDLE);
endmodule
